ws2812_multi_tx: RTL
====================

// Module: ws2812_multi_tx
// PURPOSE
//  Multi-channel WS2812 LED-strip transmitter: N_CH independent serial lines, each fed from its own byte FIFO.
//  Sits between the UART receive byte stream and the LED data pins.
//  One shared byte input is tagged with a channel index.
//  Bit timing, reset/latch length, FIFO depth and throttle thresholds are parameters.
//  Output polarity is selectable.
// PARAMETERS
//  N_CH        4     number of LED channels (>=1)
//  FIFO_DEPTH  32    bytes per channel FIFO; power of 2, >=2
//  CLK_PER_BIT 16    clocks per WS2812 bit period
//  T0H         5     clocks line active for a 0 bit; 0 < T0H < T1H
//  T1H         10    clocks line active for a 1 bit; T1H < CLK_PER_BIT
//  RESET_CLKS  1024  clocks line idle before the first byte of a frame (latch)
//  INVERT      1     1: pin = !line (external inverting driver)
//  THR_HI      20    throttle asserts when FIFO level > THR_HI
//  THR_LO      10    throttle deasserts when FIFO level < THR_LO; THR_LO <= THR_HI
// PORTS
//  clk        in   1                 system clock
//  rst        in   1                 synchronous reset, active high
//  in_data    in   8                 byte to transmit, GRB order, MSB first on the line
//  in_ch      in   CHW=max(1,clog2(N_CH))  target channel of in_data
//  in_valid   in   1                 in_data/in_ch valid
//  in_ready   out  1                 byte accepted on edge where in_valid & in_ready
//  throttle   out  N_CH              per-channel hysteretic FIFO-high flag (to UART flow control)
//  dout       out  N_CH              LED data pins (registered)
//  busy       out  N_CH              channel in SEND state
//  frame_done out  N_CH              1-cycle pulse: frame ended, line entering latch
// BEHAVIOUR
//  Reset (clk edge with rst=1):
//   - All FIFOs emptied (level 0).
//   - Every channel enters LATCH with its counter at 0.
//   - dout = INVERT ? all 1 : all 0; busy = 0; throttle = 0; frame_done = 0.
//   - rst mid-bit aborts transmission: dout is idle after that edge.
//  Input:
//   - in_ready is combinational: !full[in_ch].
//   - If in_ch >= N_CH: in_ready = 1 and the byte is discarded.
//   - Push when in_valid & in_ready.
//   - Full FIFO: no write, contents unchanged.
//  FIFO:
//   - Level width clog2(FIFO_DEPTH)+1; pointers wrap modulo FIFO_DEPTH.
//   - Push and pop on the same channel in the same cycle: both occur, level unchanged.
//   - Pop only when nonempty.
//  throttle[c]: registered.
//   - Set when level > THR_HI.
//   - Cleared when level < THR_LO.
//   - Otherwise held.
//  Serializer per channel; line = logical level, dout = line ^ INVERT:
//   - LATCH: line 0.
//     - Counter increments each cycle, saturating at RESET_CLKS-1.
//     - At saturation, if FIFO nonempty: pop into shift reg, bit=7, phase=0, line=1, go SEND.
//     - Otherwise stay in LATCH.
//   - SEND: phase counts 0..CLK_PER_BIT-1.
//     - line=1 on phase 0 through T1H-1 (bit 1) or T0H-1 (bit 0); 0 after that.
//     - At phase CLK_PER_BIT-1 with bit>0: bit-1, phase 0, line=1.
//     - At phase CLK_PER_BIT-1 with bit=0 and FIFO nonempty: pop, load, bit=7, line=1.
//       Bytes are gapless.
//     - At phase CLK_PER_BIT-1 with bit=0 and FIFO empty: go LATCH, counter 0, frame_done pulse.
//   - busy = (state==SEND).
//  Latency:
//   - Byte pushed into an empty FIFO of a channel already saturated in LATCH.
//   - dout goes active at the edge after the accepting edge.
//   - Each byte occupies exactly 8*CLK_PER_BIT clocks.
//  Channels are fully independent; a pop on one never stalls another.
// TESTING
//  1. Defaults, rst then 1024 idle clocks; push 0xA5 to ch2.
//     -> ch2 active widths 10,5,10,5,5,10,5,10 per 16-clk bit.
//     -> frame_done[2] one cycle after 128 clks.
//     -> dout[0,1,3] stay 1.
//  2. Preload ch0 with 0xFF,0x00,0x80 during LATCH.
//     -> 384 contiguous clocks of bits, no gap.
//     -> Single frame_done[0]; busy[0] high exactly 384 clks.
//  3. Push 32 bytes to ch1 before latch expires.
//     -> throttle[1] rises after level 21.
//     -> in_ready=0 for in_ch=1 at 32 while in_ready=1 for in_ch=0.
//     -> Drain: throttle[1] falls at level 9.
//  4. Push to ch0 on the exact pop cycle at level 1.
//     -> Level stays 1; the next byte starts with no gap.
//  5. rst at phase 3 of bit 4.
//     -> dout idle next edge; FIFO empty.
//     -> A new byte appears on dout only after 1024 LATCH clocks.
//  6. N_CH=3, push in_ch=3.
//     -> Accepted (in_ready=1) and dropped; no dout activity.
//     -> FIFO levels unchanged.

Source files
------------

// File: rtl/ws2812_multi_tx.sv
// Multi-channel WS2812 transmitter with one byte FIFO per LED line.
// A shared channel-tagged byte input feeds the FIFOs.
module ws2812_multi_tx #(
  parameter int N_CH        = 4,
  parameter int FIFO_DEPTH  = 32,
  parameter int CLK_PER_BIT = 16,
  parameter int T0H         = 5,
  parameter int T1H         = 10,
  parameter int RESET_CLKS  = 1024,
  parameter int INVERT      = 1,
  parameter int THR_HI      = 20,
  parameter int THR_LO      = 10,
  localparam int CHW = (N_CH > 1) ? $clog2(N_CH) : 1
) (
  input  logic            clk,
  input  logic            rst,
  input  logic [7:0]      in_data,
  input  logic [CHW-1:0]  in_ch,
  input  logic            in_valid,
  output logic            in_ready,
  output logic [N_CH-1:0] throttle,
  output logic [N_CH-1:0] dout,
  output logic [N_CH-1:0] busy,
  output logic [N_CH-1:0] frame_done
);

  localparam int AW = $clog2(FIFO_DEPTH);
  localparam int LW = AW + 1;
  localparam int CW = (RESET_CLKS > 1) ? $clog2(RESET_CLKS) : 1;
  localparam int PW = (CLK_PER_BIT > 1) ? $clog2(CLK_PER_BIT) : 1;
  localparam logic [CW-1:0] CNT_MAX = CW'(RESET_CLKS - 1);
  localparam logic [PW-1:0] PH_MAX  = PW'(CLK_PER_BIT - 1);
  localparam logic [PW-1:0] T0H_P   = PW'(T0H);
  localparam logic [PW-1:0] T1H_P   = PW'(T1H);
  localparam logic          INV     = (INVERT != 0);

  typedef enum logic {S_LATCH, S_SEND} state_e;

  logic [N_CH-1:0] full;

  // Out-of-range channels are accepted and dropped.
  always_comb begin
    in_ready = 1'b1;
    for (int c = 0; c < N_CH; c++) begin
      if (in_ch == CHW'(c)) in_ready = ~full[c];
    end
  end

  for (genvar g = 0; g < N_CH; g++) begin : g_ch
    logic [7:0]    mem_q [FIFO_DEPTH];
    logic [AW-1:0] wp_q, rp_q;
    logic [LW-1:0] lvl_q;
    logic          thr_q;
    state_e        st_q, st_d;
    logic [CW-1:0] cnt_q, cnt_d;
    logic [PW-1:0] ph_q, ph_d;
    logic [2:0]    bit_q, bit_d;
    logic [7:0]    sh_q, sh_d;
    logic          line_q, line_d;
    logic          fd_q, fd_d;
    logic          push, pop, empty;

    assign empty   = (lvl_q == '0);
    assign full[g] = (lvl_q == LW'(FIFO_DEPTH));
    assign push    = in_valid & in_ready & (in_ch == CHW'(g));

    always_ff @(posedge clk) begin
      if (push) mem_q[wp_q] <= in_data;
    end

    always_ff @(posedge clk) begin
      if (rst) begin
        wp_q  <= '0;
        rp_q  <= '0;
        lvl_q <= '0;
        thr_q <= 1'b0;
      end else begin
        if (push) wp_q <= wp_q + 1'b1;
        if (pop)  rp_q <= rp_q + 1'b1;
        if (push && !pop)      lvl_q <= lvl_q + 1'b1;
        else if (pop && !push) lvl_q <= lvl_q - 1'b1;
        if (int'(lvl_q) > THR_HI)      thr_q <= 1'b1;
        else if (int'(lvl_q) < THR_LO) thr_q <= 1'b0;
      end
    end

    always_comb begin
      st_d   = st_q;
      cnt_d  = cnt_q;
      ph_d   = ph_q;
      bit_d  = bit_q;
      sh_d   = sh_q;
      line_d = line_q;
      fd_d   = 1'b0;
      pop    = 1'b0;
      unique case (st_q)
        S_LATCH: begin
          line_d = 1'b0;
          if (cnt_q != CNT_MAX) begin
            cnt_d = cnt_q + 1'b1;
          end else if (!empty) begin
            pop    = 1'b1;
            sh_d   = mem_q[rp_q];
            bit_d  = 3'd7;
            ph_d   = '0;
            line_d = 1'b1;
            st_d   = S_SEND;
          end
        end
        S_SEND: begin
          if (ph_q != PH_MAX) begin
            ph_d   = ph_q + 1'b1;
            line_d = ph_d < (sh_q[bit_q] ? T1H_P : T0H_P);
          end else if (bit_q != 3'd0) begin
            bit_d  = bit_q - 1'b1;
            ph_d   = '0;
            line_d = 1'b1;
          end else if (!empty) begin
            pop    = 1'b1;
            sh_d   = mem_q[rp_q];
            bit_d  = 3'd7;
            ph_d   = '0;
            line_d = 1'b1;
          end else begin
            st_d   = S_LATCH;
            cnt_d  = '0;
            line_d = 1'b0;
            fd_d   = 1'b1;
          end
        end
      endcase
    end

    always_ff @(posedge clk) begin
      if (rst) begin
        st_q   <= S_LATCH;
        cnt_q  <= '0;
        ph_q   <= '0;
        bit_q  <= '0;
        sh_q   <= '0;
        line_q <= 1'b0;
        fd_q   <= 1'b0;
      end else begin
        st_q   <= st_d;
        cnt_q  <= cnt_d;
        ph_q   <= ph_d;
        bit_q  <= bit_d;
        sh_q   <= sh_d;
        line_q <= line_d;
        fd_q   <= fd_d;
      end
    end

    assign dout[g]       = line_q ^ INV;
    assign busy[g]       = (st_q == S_SEND);
    assign frame_done[g] = fd_q;
    assign throttle[g]   = thr_q;
  end

endmodule
